// File: rtl/vertex_cl_packer_pkg.sv
// Shared types and constants for the vertex write-back packer.
package vertex_cl_packer_pkg;

    localparam int VERTEX_W     = 32;
    localparam int CL_W         = 512;
    localparam int VERTS_PER_CL = 16;

    typedef logic [VERTEX_W-1:0] vertex_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/vertex_line_buf.sv
// One-line fill buffer: 16 vertex slots, valid mask, line index and busy flag.
// A clear and a write in the same cycle leave a fresh line holding only that vertex.
import vertex_cl_packer_pkg::*;

module vertex_line_buf #(
    parameter int LINE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr,
    input  logic [3:0]              slot,
    input  vertex_t                 vertex,
    input  logic [LINE_W-1:0]       w_line,
    output logic [CL_W-1:0]         data,
    output logic [VERTS_PER_CL-1:0] mask,
    output logic [LINE_W-1:0]       line,
    output logic                    busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            mask <= '0;
            line <= '0;
            busy <= 1'b0;
        end else begin
            if (clr) begin
                data <= '0;
                mask <= '0;
                busy <= 1'b0;
            end
            // Later assignments override the clear for the written slot.
            if (wr) begin
                data[slot*VERTEX_W +: VERTEX_W] <= vertex;
                mask[slot] <= 1'b1;
                line <= w_line;
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vertex_cl_packer.sv
// Coalesces single vertex updates into masked 512-bit cachelines.
// Optional VERTEX_PACKER_AUTO_EMIT_EN: emit a line as soon as all 16 slots are written.
import vertex_cl_packer_pkg::*;

module vertex_cl_packer #(
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  vertex_t                 vertex_in,
    input  logic [ADDR_W-1:0]       v_addr,
    input  logic                    v_valid,
    output logic                    v_ready,
    input  logic                    flush_in,
    output logic                    flush_done,
    output logic [CL_W-1:0]         cl_out,
    output logic [ADDR_W-5:0]       cl_addr,
    output logic [VERTS_PER_CL-1:0] cl_mask,
    output logic                    cl_valid,
    input  logic                    cl_ready
);

    localparam int LINE_W = ADDR_W - 4;

    logic [1:0]              state;
    logic [CL_W-1:0]         buf_data;
    logic [VERTS_PER_CL-1:0] buf_mask;
    logic [LINE_W-1:0]       buf_line;
    logic                    busy;

    logic [CL_W-1:0]         m_data;
    logic [VERTS_PER_CL-1:0] m_mask;
    logic [LINE_W-1:0]       m_line;
    logic [LINE_W-1:0]       v_line;
    logic [3:0]              slot;
    logic active, out_free, fire, swap, drain, flush_take, auto_full;
    logic clr, wr;

    assign v_line     = v_addr[ADDR_W-1:4];
    assign slot       = v_addr[3:0];
    assign active     = (state == ST_EMPTY) || (state == ST_FILL);
    assign out_free   = !cl_valid || cl_ready;
    assign v_ready    = !rst && active && out_free;
    assign fire       = v_valid && v_ready;
    assign flush_take = flush_in && active;
    assign flush_done = (state == ST_DONE);

    // Buffer contents as they would look with this cycle's vertex absorbed.
    always_comb begin
        m_data = buf_data;
        m_mask = buf_mask;
        if (fire) begin
            m_data[slot*VERTEX_W +: VERTEX_W] = vertex_in;
            m_mask[slot] = 1'b1;
        end
    end

    assign m_line = fire ? v_line : buf_line;

`ifdef VERTEX_PACKER_AUTO_EMIT_EN
    assign auto_full = active && (m_mask == '1);
`else
    assign auto_full = 1'b0;
`endif

    // swap: emit the stored line and restart with the new vertex.
    // drain: emit the merged line and leave the buffer empty.
    assign swap  = fire && busy && (v_line != buf_line);
    assign drain = !swap && out_free && (busy || fire)
                && ((state == ST_FLUSH) || flush_take || auto_full);
    assign clr   = swap || drain;
    assign wr    = fire && !drain;

    vertex_line_buf #(
        .LINE_W (LINE_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .wr     (wr),
        .slot   (slot),
        .vertex (vertex_in),
        .w_line (v_line),
        .data   (buf_data),
        .mask   (buf_mask),
        .line   (buf_line),
        .busy   (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cl_valid <= 1'b0;
            cl_out   <= '0;
            cl_addr  <= '0;
            cl_mask  <= '0;
        end else if (swap) begin
            cl_valid <= 1'b1;
            cl_out   <= buf_data;
            cl_addr  <= buf_line;
            cl_mask  <= buf_mask;
        end else if (drain) begin
            cl_valid <= 1'b1;
            cl_out   <= m_data;
            cl_addr  <= m_line;
            cl_mask  <= m_mask;
        end else if (cl_ready) begin
            cl_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY, ST_FILL: begin
                    if (flush_take)
                        state <= ST_FLUSH;
                    else if (swap)
                        state <= ST_FILL;
                    else if (drain)
                        state <= ST_EMPTY;
                    else if (fire)
                        state <= ST_FILL;
                end
                ST_FLUSH: begin
                    if (!busy && !cl_valid)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_EMPTY;
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_cl_packer.sv
// Directed bench for vertex_cl_packer with hand-computed expected lines.
// Emitted lines are captured into queues and compared in order.
import vertex_cl_packer_pkg::*;

module tb_vertex_cl_packer;

    logic          clk;
    logic          rst;
    vertex_t       vertex_in;
    logic [7:0]    v_addr;
    logic          v_valid;
    logic          v_ready;
    logic          flush_in;
    logic          flush_done;
    logic [511:0]  cl_out;
    logic [3:0]    cl_addr;
    logic [15:0]   cl_mask;
    logic          cl_valid;
    logic          cl_ready;

    int checks = 0;
    int failures = 0;

    logic [511:0] q_out[$];
    logic [3:0]   q_addr[$];
    logic [15:0]  q_mask[$];

    vertex_cl_packer #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .vertex_in  (vertex_in),
        .v_addr     (v_addr),
        .v_valid    (v_valid),
        .v_ready    (v_ready),
        .flush_in   (flush_in),
        .flush_done (flush_done),
        .cl_out     (cl_out),
        .cl_addr    (cl_addr),
        .cl_mask    (cl_mask),
        .cl_valid   (cl_valid),
        .cl_ready   (cl_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees what the next edge will take.
    always @(negedge clk) begin
        if (!rst && cl_valid && cl_ready) begin
            q_out.push_back(cl_out);
            q_addr.push_back(cl_addr);
            q_mask.push_back(cl_mask);
        end
    end

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] slot_line(input int s, input logic [31:0] d);
        logic [511:0] l;
        l = '0;
        l[s*32 +: 32] = d;
        return l;
    endfunction

    task automatic send(input logic [7:0] a, input logic [31:0] d);
        int n;
        n = 0;
        v_valid = 1'b1;
        v_addr = a;
        vertex_in = d;
        #1;
        while (!v_ready && n < 64) begin
            tick();
            n++;
        end
        if (!v_ready) chk("send_ready", v_ready, 1);
        tick();
        v_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!flush_done && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, flush_done, 1);
        tick();
        chk({tag, "_pulse"}, flush_done, 0);
    endtask

    task automatic check_line(input string tag, input logic [511:0] eo,
                              input logic [3:0] ea, input logic [15:0] em);
        chk({tag, "_present"}, q_out.size() > 0, 1);
        if (q_out.size() > 0) begin
            chk({tag, "_data"}, q_out.pop_front(), eo);
            chk({tag, "_addr"}, q_addr.pop_front(), ea);
            chk({tag, "_mask"}, q_mask.pop_front(), em);
        end
    endtask

    logic [511:0] exp;

    initial begin
        rst = 1'b1;
        vertex_in = '0;
        v_addr = '0;
        v_valid = 1'b0;
        flush_in = 1'b0;
        cl_ready = 1'b1;
        tick(); tick(); tick();

        chk("rst_v_ready", v_ready, 0);
        chk("rst_cl_valid", cl_valid, 0);
        chk("rst_cl_out", cl_out, 0);
        chk("rst_cl_addr", cl_addr, 0);
        chk("rst_cl_mask", cl_mask, 0);
        chk("rst_flush_done", flush_done, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_v_ready", v_ready, 1);

        // Full line closed by a line change, remainder flushed.
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[i*32 +: 32] = 32'h100 + i;
            send(8'(i), 32'h100 + i);
        end
        send(8'd16, 32'h200);
`ifndef VERTEX_PACKER_AUTO_EMIT_EN
        chk("linechg_valid", cl_valid, 1);
`endif
        tick();
        check_line("full", exp, 4'd0, 16'hFFFF);
        do_flush();
        wait_done("full_flush");
        check_line("line1", slot_line(0, 32'h200), 4'd1, 16'h0001);

        // Sparse flush.
        send(8'd3, 32'hAA);
        send(8'd7, 32'hBB);
        do_flush();
        wait_done("sparse");
        check_line("sparse", slot_line(3, 32'hAA) | slot_line(7, 32'hBB),
                   4'd0, 16'h0088);

        // Overwrite, with flush timing: cl_valid N+1, flush_done N+3.
        send(8'd5, 32'hA);
        send(8'd5, 32'hB);
        do_flush();
        chk("ovw_valid_n1", cl_valid, 1);
        tick();
        chk("ovw_done_n2", flush_done, 0);
        tick();
        chk("ovw_done_n3", flush_done, 1);
        tick();
        chk("ovw_done_n4", flush_done, 0);
        check_line("ovw", slot_line(5, 32'hB), 4'd0, 16'h0020);

        // Backpressure.
        cl_ready = 1'b0;
        send(8'h30, 32'h1);
        send(8'h40, 32'h2);
        v_valid = 1'b1;
        v_addr = 8'h50;
        vertex_in = 32'h3;
        #1;
        chk("bp_v_ready", v_ready, 0);
        chk("bp_cl_valid", cl_valid, 1);
        tick(); tick();
        chk("bp_hold_data", cl_out, slot_line(0, 32'h1));
        chk("bp_hold_addr", cl_addr, 4'd3);
        chk("bp_v_ready2", v_ready, 0);
        chk("bp_no_take", q_out.size(), 0);
        cl_ready = 1'b1;
        send(8'h50, 32'h3);
        do_flush();
        wait_done("bp");
        check_line("bp_l3", slot_line(0, 32'h1), 4'd3, 16'h0001);
        check_line("bp_l4", slot_line(0, 32'h2), 4'd4, 16'h0001);
        check_line("bp_l5", slot_line(0, 32'h3), 4'd5, 16'h0001);
        chk("bp_no_extra", q_out.size(), 0);

        // Empty flush: done two cycles later.
        do_flush();
        chk("eflush_n1", flush_done, 0);
        tick();
        chk("eflush_n2", flush_done, 1);
        tick();
        chk("eflush_n3", flush_done, 0);
        chk("eflush_no_line", q_out.size(), 0);

        // Flush together with a transfer.
        v_valid = 1'b1;
        v_addr = 8'd9;
        vertex_in = 32'h99;
        flush_in = 1'b1;
        #1;
        chk("simul_v_ready", v_ready, 1);
        tick();
        v_valid = 1'b0;
        flush_in = 1'b0;
        wait_done("simul");
        check_line("simul", slot_line(9, 32'h99), 4'd0, 16'h0200);

        // Reset with a partial line buffered.
        for (int i = 0; i < 4; i++) send(8'(i), 32'h300 + i);
        rst = 1'b1;
        #1;
        chk("mid_rst_v_ready", v_ready, 0);
        tick();
        chk("mid_rst_cl_valid", cl_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_no_line", q_out.size(), 0);
        do_flush();
        wait_done("mid_rst");
        chk("mid_rst_discard", q_out.size(), 0);

        // Full line 2 with no further input.
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[i*32 +: 32] = 32'h400 + i;
            send(8'h20 + 8'(i), 32'h400 + i);
        end
        tick(); tick(); tick();
`ifdef VERTEX_PACKER_AUTO_EMIT_EN
        check_line("auto", exp, 4'd2, 16'hFFFF);
`else
        chk("noauto_held", q_out.size(), 0);
        chk("noauto_valid", cl_valid, 0);
        do_flush();
        wait_done("noauto");
        check_line("noauto", exp, 4'd2, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
